// File: rtl/sc_dual_block_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// sc_dual_block_ram_arbiter_if : client request/response and RAM command bus
// Revision: 1.0
// ============================================================================
interface sc_dual_block_ram_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                     req0_valid_i;
  logic                     req0_ready_o;
  logic                     req0_write_i;
  logic [ADDRESS_WIDTH-1:0] req0_address_i;
  logic [DATA_WIDTH-1:0]    req0_data_i;
  logic [BE_WIDTH-1:0]      req0_byte_enable_i;
  logic                     req1_valid_i;
  logic                     req1_ready_o;
  logic                     req1_write_i;
  logic [ADDRESS_WIDTH-1:0] req1_address_i;
  logic [DATA_WIDTH-1:0]    req1_data_i;
  logic [BE_WIDTH-1:0]      req1_byte_enable_i;
  logic                     rsp0_valid_o;
  logic [DATA_WIDTH-1:0]    rsp0_data_o;
  logic                     rsp1_valid_o;
  logic [DATA_WIDTH-1:0]    rsp1_data_o;
  logic [DATA_WIDTH-1:0]    ram_wr_data_o;
  logic [ADDRESS_WIDTH-1:0] ram_wr_address_o;
  logic                     ram_wr_enable_o;
  logic [BE_WIDTH-1:0]      ram_wr_byte_enable_o;
  logic [ADDRESS_WIDTH-1:0] ram_rd_address_o;
  logic                     ram_rd_enable_o;
  logic [DATA_WIDTH-1:0]    ram_rd_data_i;
  logic                     ram_rd_valid_i;

  // Arbiter side
  modport slave (
    input  req0_valid_i, req0_write_i, req0_address_i, req0_data_i, req0_byte_enable_i,
    input  req1_valid_i, req1_write_i, req1_address_i, req1_data_i, req1_byte_enable_i,
    output req0_ready_o, req1_ready_o,
    output rsp0_valid_o, rsp0_data_o, rsp1_valid_o, rsp1_data_o,
    output ram_wr_data_o, ram_wr_address_o, ram_wr_enable_o, ram_wr_byte_enable_o,
    output ram_rd_address_o, ram_rd_enable_o,
    input  ram_rd_data_i, ram_rd_valid_i
  );

  // Clients and RAM side
  modport master (
    output req0_valid_i, req0_write_i, req0_address_i, req0_data_i, req0_byte_enable_i,
    output req1_valid_i, req1_write_i, req1_address_i, req1_data_i, req1_byte_enable_i,
    input  req0_ready_o, req1_ready_o,
    input  rsp0_valid_o, rsp0_data_o, rsp1_valid_o, rsp1_data_o,
    input  ram_wr_data_o, ram_wr_address_o, ram_wr_enable_o, ram_wr_byte_enable_o,
    input  ram_rd_address_o, ram_rd_enable_o,
    output ram_rd_data_i, ram_rd_valid_i
  );
endinterface
`default_nettype wire

// File: rtl/sc_dual_block_ram_arbiter.sv
`default_nettype none
// ============================================================================
// sc_dual_block_ram_arbiter : two-client round-robin arbiter for a SDP block RAM
// Revision: 1.0
// ============================================================================
module sc_dual_block_ram_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  sc_dual_block_ram_arbiter_if.slave bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [1:0]               wr_cand, rd_cand, wr_grant, rd_grant;
  logic                     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                     ram_wr_enable_q, ram_wr_enable_d;
  logic [DATA_WIDTH-1:0]    ram_wr_data_q, ram_wr_data_d;
  logic [ADDRESS_WIDTH-1:0] ram_wr_address_q, ram_wr_address_d;
  logic [BE_WIDTH-1:0]      ram_wr_byte_enable_q, ram_wr_byte_enable_d;
  logic                     ram_rd_enable_q, ram_rd_enable_d;
  logic [ADDRESS_WIDTH-1:0] ram_rd_address_q, ram_rd_address_d;
  logic                     rd_tag1_q, rd_tag1_d, rd_tag2_q, rd_tag2_d;
  logic                     rd_inflight2_q, rd_inflight2_d;

  always_comb begin
    wr_cand = {bus.req1_valid_i &  bus.req1_write_i, bus.req0_valid_i &  bus.req0_write_i};
    rd_cand = {bus.req1_valid_i & ~bus.req1_write_i, bus.req0_valid_i & ~bus.req0_write_i};
    // Pointer value k means client k wins when both clients contend.
    wr_grant[0] = wr_cand[0] & (~wr_cand[1] | ~wr_ptr_q);
    wr_grant[1] = wr_cand[1] & (~wr_cand[0] |  wr_ptr_q);
    rd_grant[0] = rd_cand[0] & (~rd_cand[1] | ~rd_ptr_q);
    rd_grant[1] = rd_cand[1] & (~rd_cand[0] |  rd_ptr_q);

    wr_ptr_d             = wr_ptr_q;
    ram_wr_enable_d      = |wr_grant;
    ram_wr_data_d        = ram_wr_data_q;
    ram_wr_address_d     = ram_wr_address_q;
    ram_wr_byte_enable_d = ram_wr_byte_enable_q;
    if (wr_grant[0]) begin
      wr_ptr_d             = 1'b1;
      ram_wr_data_d        = bus.req0_data_i;
      ram_wr_address_d     = bus.req0_address_i;
      ram_wr_byte_enable_d = bus.req0_byte_enable_i;
    end else if (wr_grant[1]) begin
      wr_ptr_d             = 1'b0;
      ram_wr_data_d        = bus.req1_data_i;
      ram_wr_address_d     = bus.req1_address_i;
      ram_wr_byte_enable_d = bus.req1_byte_enable_i;
    end

    rd_ptr_d         = rd_ptr_q;
    ram_rd_enable_d  = |rd_grant;
    ram_rd_address_d = ram_rd_address_q;
    rd_tag1_d        = rd_tag1_q;
    if (rd_grant[0]) begin
      rd_ptr_d         = 1'b1;
      ram_rd_address_d = bus.req0_address_i;
      rd_tag1_d        = 1'b0;
    end else if (rd_grant[1]) begin
      rd_ptr_d         = 1'b0;
      ram_rd_address_d = bus.req1_address_i;
      rd_tag1_d        = 1'b1;
    end
    // ram_rd_enable_q doubles as the first-stage in-flight flag.
    rd_tag2_d      = rd_tag1_q;
    rd_inflight2_d = ram_rd_enable_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q             <= 1'b0;
      rd_ptr_q             <= 1'b0;
      ram_wr_enable_q      <= 1'b0;
      ram_wr_data_q        <= '0;
      ram_wr_address_q     <= '0;
      ram_wr_byte_enable_q <= '0;
      ram_rd_enable_q      <= 1'b0;
      ram_rd_address_q     <= '0;
      rd_tag1_q            <= 1'b0;
      rd_tag2_q            <= 1'b0;
      rd_inflight2_q       <= 1'b0;
    end else begin
      wr_ptr_q             <= wr_ptr_d;
      rd_ptr_q             <= rd_ptr_d;
      ram_wr_enable_q      <= ram_wr_enable_d;
      ram_wr_data_q        <= ram_wr_data_d;
      ram_wr_address_q     <= ram_wr_address_d;
      ram_wr_byte_enable_q <= ram_wr_byte_enable_d;
      ram_rd_enable_q      <= ram_rd_enable_d;
      ram_rd_address_q     <= ram_rd_address_d;
      rd_tag1_q            <= rd_tag1_d;
      rd_tag2_q            <= rd_tag2_d;
      rd_inflight2_q       <= rd_inflight2_d;
    end
  end

  assign bus.req0_ready_o         = ~rst_i & (wr_grant[0] | rd_grant[0]);
  assign bus.req1_ready_o         = ~rst_i & (wr_grant[1] | rd_grant[1]);
  assign bus.ram_wr_enable_o      = ram_wr_enable_q;
  assign bus.ram_wr_data_o        = ram_wr_data_q;
  assign bus.ram_wr_address_o     = ram_wr_address_q;
  assign bus.ram_wr_byte_enable_o = ram_wr_byte_enable_q;
  assign bus.ram_rd_enable_o      = ram_rd_enable_q;
  assign bus.ram_rd_address_o     = ram_rd_address_q;
  assign bus.rsp0_valid_o         = bus.ram_rd_valid_i & rd_inflight2_q & ~rd_tag2_q;
  assign bus.rsp1_valid_o         = bus.ram_rd_valid_i & rd_inflight2_q &  rd_tag2_q;
  assign bus.rsp0_data_o          = bus.rsp0_valid_o ? bus.ram_rd_data_i : '0;
  assign bus.rsp1_data_o          = bus.rsp1_valid_o ? bus.ram_rd_data_i : '0;
endmodule
`default_nettype wire

// File: tb/tb_sc_dual_block_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_sc_dual_block_ram_arbiter : directed bench with response scoreboard
// Revision: 1.0
// ============================================================================
module tb_sc_dual_block_ram_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sc_dual_block_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  sc_dual_block_ram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Write-first simple-dual-port RAM with one-cycle registered read; not reset.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          ram_valid_q = 1'b0;
  logic [DW-1:0] ram_data_q  = '0;
  logic          force_valid = 1'b0;
  assign bus.ram_rd_valid_i = ram_valid_q | force_valid;
  assign bus.ram_rd_data_i  = ram_data_q;

  always @(posedge clk) begin
    if (bus.ram_wr_enable_o)
      for (int b = 0; b < BW; b++)
        if (bus.ram_wr_byte_enable_o[b])
          mem[bus.ram_wr_address_o][8*b +: 8] = bus.ram_wr_data_o[8*b +: 8];
    ram_valid_q <= bus.ram_rd_enable_o;
    if (bus.ram_rd_enable_o) ram_data_q <= mem[bus.ram_rd_address_o];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  task automatic push(input int n, input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + 2;
    if (n == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic mon(input int n);
    logic          v;
    logic [DW-1:0] d;
    exp_t          e;
    v = (n == 0) ? bus.rsp0_valid_o : bus.rsp1_valid_o;
    d = (n == 0) ? bus.rsp0_data_o  : bus.rsp1_data_o;
    if (v === 1'b1) begin
      if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
        chk($sformatf("rsp%0d_unexpected", n), 64'(v), 64'd0);
      end else begin
        e = (n == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("rsp%0d_data", n), 64'(d), 64'(e.data));
        chk($sformatf("rsp%0d_cycle", n), 64'(cyc), 64'(e.cyc));
      end
    end else if (bus.ram_rd_valid_i === 1'b1) begin
      chk($sformatf("rsp%0d_data_zero", n), 64'(d), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
    if (n == 0) begin
      bus.req0_valid_i = v; bus.req0_write_i = w; bus.req0_address_i = a;
      bus.req0_data_i = d;  bus.req0_byte_enable_i = be;
    end else begin
      bus.req1_valid_i = v; bus.req1_write_i = w; bus.req1_address_i = a;
      bus.req1_data_i = d;  bus.req1_byte_enable_i = be;
    end
  endtask

  task automatic idle();
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[10'h003] = 32'h1122_3344;
    mem[10'h010] = 32'hA0A0_0010;
    mem[10'h020] = 32'hB0B0_0020;

    // Reset: requests are not accepted, nothing is driven to the RAM.
    idle();
    set_req(0, 1'b1, 1'b1, 10'h001, 32'h1, 4'hF);
    @(negedge clk);
    chk("reset_ready0", 64'(bus.req0_ready_o), 64'd0);
    chk("reset_ready1", 64'(bus.req1_ready_o), 64'd0);
    chk("reset_wr_en", 64'(bus.ram_wr_enable_o), 64'd0);
    chk("reset_rd_en", 64'(bus.ram_rd_enable_o), 64'd0);
    idle();
    tick();
    rst = 1'b0;
    tick();
    force_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stray_valid_rsp0", 64'(bus.rsp0_valid_o), 64'd0);
      chk("stray_valid_rsp1", 64'(bus.rsp1_valid_o), 64'd0);
      chk("idle_wr_en", 64'(bus.ram_wr_enable_o), 64'd0);
      tick();
    end
    force_valid = 1'b0;

    // Client 0 write followed by read of the same address.
    set_req(0, 1'b1, 1'b1, 10'h005, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    chk("wr_ready0", 64'(bus.req0_ready_o), 64'd1);
    chk("wr_ready1", 64'(bus.req1_ready_o), 64'd0);
    tick();
    idle();
    @(negedge clk);
    chk("wr_en", 64'(bus.ram_wr_enable_o), 64'd1);
    chk("wr_addr", 64'(bus.ram_wr_address_o), 64'h005);
    chk("wr_data", 64'(bus.ram_wr_data_o), 64'hDEAD_BEEF);
    chk("wr_be", 64'(bus.ram_wr_byte_enable_o), 64'hF);
    tick();
    set_req(0, 1'b1, 1'b0, 10'h005, '0, '0);
    @(negedge clk);
    chk("wr_en_pulse", 64'(bus.ram_wr_enable_o), 64'd0);
    chk("rd_ready0", 64'(bus.req0_ready_o), 64'd1);
    push(0, 32'hDEAD_BEEF);
    tick();
    idle();
    @(negedge clk);
    chk("rd_en", 64'(bus.ram_rd_enable_o), 64'd1);
    chk("rd_addr", 64'(bus.ram_rd_address_o), 64'h005);
    repeat (3) tick();

    // Both clients read continuously: grants alternate starting at client 0.
    do_reset();
    set_req(0, 1'b1, 1'b0, 10'h010, '0, '0);
    set_req(1, 1'b1, 1'b0, 10'h020, '0, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rr_rd_ready0_%0d", i), 64'(bus.req0_ready_o), 64'((i % 2) == 0));
      chk($sformatf("rr_rd_ready1_%0d", i), 64'(bus.req1_ready_o), 64'((i % 2) == 1));
      if ((i % 2) == 0) push(0, 32'hA0A0_0010);
      else              push(1, 32'hB0B0_0020);
      tick();
    end
    idle();
    repeat (3) tick();

    // Partial write and same-address read in one cycle: read sees new bytes.
    set_req(0, 1'b1, 1'b1, 10'h003, 32'h0000_ABCD, 4'b0011);
    set_req(1, 1'b1, 1'b0, 10'h003, '0, '0);
    @(negedge clk);
    chk("same_ready0", 64'(bus.req0_ready_o), 64'd1);
    chk("same_ready1", 64'(bus.req1_ready_o), 64'd1);
    push(1, 32'h1122_ABCD);
    tick();
    idle();
    @(negedge clk);
    chk("same_wr_be", 64'(bus.ram_wr_byte_enable_o), 64'h3);
    chk("same_rd_en", 64'(bus.ram_rd_enable_o), 64'd1);
    repeat (3) tick();

    // Write contention alternates from client 0, then a read stream runs alongside writes.
    do_reset();
    set_req(0, 1'b1, 1'b1, 10'h040, 32'h0C0C_0C0C, 4'hF);
    set_req(1, 1'b1, 1'b1, 10'h050, 32'h1515_1515, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rr_wr_ready0_%0d", i), 64'(bus.req0_ready_o), 64'((i % 2) == 0));
      chk($sformatf("rr_wr_ready1_%0d", i), 64'(bus.req1_ready_o), 64'((i % 2) == 1));
      if (i > 0)
        chk($sformatf("rr_wr_addr_%0d", i), 64'(bus.ram_wr_address_o),
            (((i - 1) % 2) == 0) ? 64'h040 : 64'h050);
      tick();
    end
    set_req(0, 1'b1, 1'b1, 10'h060, 32'h6666_6666, 4'hF);
    set_req(1, 1'b1, 1'b0, 10'h010, '0, '0);
    @(negedge clk);
    chk("rr_wr_addr_last", 64'(bus.ram_wr_address_o), 64'h050);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("stream_wr_ready0_%0d", i), 64'(bus.req0_ready_o), 64'd1);
      chk($sformatf("stream_rd_ready1_%0d", i), 64'(bus.req1_ready_o), 64'd1);
      push(1, 32'hA0A0_0010);
      tick();
    end
    idle();
    repeat (3) tick();

    // Two client 0 reads in flight (read pointer now 1), then a one-cycle reset.
    set_req(0, 1'b1, 1'b0, 10'h010, '0, '0);
    @(negedge clk);
    chk("flight_ready0_a", 64'(bus.req0_ready_o), 64'd1);
    tick();
    @(negedge clk);
    chk("flight_ready0_b", 64'(bus.req0_ready_o), 64'd1);
    tick();
    rst = 1'b1;
    idle();
    @(negedge clk);
    chk("flight_rst_rsp0", 64'(bus.rsp0_valid_o), 64'd0);
    chk("flight_rst_rd_en", 64'(bus.ram_rd_enable_o), 64'd0);
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 10'h010, '0, '0);
    set_req(1, 1'b1, 1'b0, 10'h020, '0, '0);
    @(negedge clk);
    chk("post_rst_rsp0", 64'(bus.rsp0_valid_o), 64'd0);
    chk("post_rst_ready0", 64'(bus.req0_ready_o), 64'd1);
    chk("post_rst_ready1", 64'(bus.req1_ready_o), 64'd0);
    push(0, 32'hA0A0_0010);
    tick();
    @(negedge clk);
    chk("post_rst_ready1_next", 64'(bus.req1_ready_o), 64'd1);
    push(1, 32'hB0B0_0020);
    tick();
    idle();
    repeat (4) tick();

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
